// File: rtl/ci_dispatcher.sv
// Registered CI front end: captures a CPU request, broadcasts a one-cycle start to all
// CI units, merges the first done/result, returns a one-cycle done. Optional timeout: CI_TIMEOUT_EN.
`timescale 1ns/1ps
module ci_dispatcher #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ciStart,
  input  logic [31:0]             ciValueA,
  input  logic [31:0]             ciValueB,
  input  logic [7:0]              ciN,
  output logic                    ciDone,
  output logic [31:0]             ciResult,
  output logic                    busy,
  output logic                    slvStart,
  output logic [31:0]             slvValueA,
  output logic [31:0]             slvValueB,
  output logic [7:0]              slvCiN,
  input  logic [NUM_SLAVES-1:0]   slvDone,
  input  logic [32*NUM_SLAVES-1:0] slvResult,
  output logic [1:0]              errSticky,
  output logic [1:0]              dbgState
);

  // Handshake: ciStart is a one-cycle strobe honoured only in IDLE; ciDone is a one-cycle
  // pulse with ciResult valid only alongside it; any slvDone bit counts only in ISSUE/WAIT.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } stateT;

  stateT       state, nextState;
  logic [31:0] resultReg;
  logic [31:0] mergedResult;
  logic        anyDone;
  logic        multiDone;
  logic        accepting;
  logic        acceptReq;
  logic        timeoutHit;

  always_comb begin
    mergedResult = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slvDone[k]) mergedResult = mergedResult | slvResult[32*k +: 32];
    end
  end

  assign anyDone   = |slvDone;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multiDone = |(slvDone & (slvDone - NUM_SLAVES'(1)));
  assign accepting = ((state == S_ISSUE) || (state == S_WAIT)) && anyDone;
  assign acceptReq = (state == S_IDLE) && ciStart;

`ifdef CI_TIMEOUT_EN
  logic [15:0] waitCnt;

  assign timeoutHit = (state == S_WAIT) && (waitCnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (acceptReq) begin
      waitCnt <= '0;
    end else if (state == S_WAIT) begin
      waitCnt <= waitCnt + 16'd1;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeoutHit    = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:    if (ciStart) nextState = S_ISSUE;
      S_ISSUE:   nextState = anyDone ? S_RESPOND : S_WAIT;
      S_WAIT:    if (anyDone || timeoutHit) nextState = S_RESPOND;
      S_RESPOND: nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      slvValueA <= '0;
      slvValueB <= '0;
      slvCiN    <= '0;
      resultReg <= '0;
      errSticky <= '0;
    end else begin
      state <= nextState;
      if (acceptReq) begin
        slvValueA <= ciValueA;
        slvValueB <= ciValueB;
        slvCiN    <= ciN;
      end
      // A done in the timeout cycle takes priority over the timeout pattern.
      if (accepting) begin
        resultReg <= mergedResult;
      end else if (timeoutHit) begin
        resultReg <= 32'hDEADBEEF;
      end
      if (ciStart && (state != S_IDLE)) errSticky[0] <= 1'b1;
      if (accepting && multiDone)       errSticky[1] <= 1'b1;
    end
  end

  assign slvStart = (state == S_ISSUE);
  assign busy     = (state == S_ISSUE) || (state == S_WAIT);
  assign ciDone   = (state == S_RESPOND);
  assign ciResult = (state == S_RESPOND) ? resultReg : 32'h0;
  assign dbgState = state;

endmodule
